// File: rtl/decoder_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_scan_sequencer_if
//  Description : Handshake and decoder-drive bundle for the scan sequencer.
//                master = requester / decoder side, slave = sequencer.
//  Signals     : start, stop, mode, dwell  (requester -> sequencer)
//                en_n, w1, w0              (sequencer -> decoder)
//                busy, done, code_strobe   (sequencer -> requester)
//  Revision    : 1.0 - initial release
// ============================================================================
interface decoder_scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic               en_n;
    logic               w1;
    logic               w0;
    logic               busy;
    logic               done;
    logic               code_strobe;

    modport master (
        output start, stop, mode, dwell,
        input  en_n, w1, w0, busy, done, code_strobe
    );

    modport slave (
        input  start, stop, mode, dwell,
        output en_n, w1, w0, busy, done, code_strobe
    );
endinterface
`default_nettype wire

// File: rtl/decoder_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_scan_sequencer
//  Description : Steps a 2-to-4 decoder through select codes 00,01,10,11,
//                holding each for a programmable dwell. Single-pass or
//                continuous mode; start/stop/busy/done handshake.
//                All outputs are flop outputs (glitch-free selects).
//  Ports       : clk   - rising-edge clock
//                rst_n - synchronous active-low reset
//                bus   - decoder_scan_sequencer_if.slave
//                        in : start, stop, mode, dwell
//                        out: en_n, w1, w0, busy, done, code_strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    decoder_scan_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] c_one = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             r_state,  w_state;
    logic [1:0]         r_code,   w_code;
    logic [DWELL_W-1:0] r_cnt,    w_cnt;
    logic [DWELL_W-1:0] r_dwell,  w_dwell;
    logic               r_mode,   w_mode;
    logic               r_en_n,   w_en_n;
    logic               r_busy,   w_busy;
    logic               r_done,   w_done;
    logic               r_strobe, w_strobe;

    // A dwell of zero behaves as one so the counter is never loaded with 0.
    logic [DWELL_W-1:0] w_dwell_eff;
    assign w_dwell_eff = (bus.dwell == '0) ? c_one : bus.dwell;

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // and registered, so what the decoder sees always matches r_state.
    always_comb begin
        w_state  = r_state;
        w_code   = 2'b00;
        w_cnt    = '0;
        w_dwell  = r_dwell;
        w_mode   = r_mode;
        w_en_n   = 1'b1;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_strobe = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // stop beats start when both are asserted
                if (bus.start && !bus.stop) begin
                    w_state  = ST_RUN;
                    w_mode   = bus.mode;
                    w_dwell  = w_dwell_eff;
                    w_cnt    = w_dwell_eff;
                    w_en_n   = 1'b0;
                    w_busy   = 1'b1;
                    w_strobe = 1'b1;
                end
            end

            ST_RUN: begin
                if (bus.stop) begin
                    // abort takes priority over any pending code advance
                    w_state = ST_IDLE;
                end else if (r_cnt == c_one) begin
                    if (r_code == 2'b11 && r_mode) begin
                        w_state = ST_FINISH;
                        w_done  = 1'b1;
                    end else begin
                        // 11 -> 00 wraps naturally in continuous mode
                        w_code   = r_code + 2'd1;
                        w_cnt    = r_dwell;
                        w_en_n   = 1'b0;
                        w_busy   = 1'b1;
                        w_strobe = 1'b1;
                    end
                end else begin
                    w_code = r_code;
                    w_cnt  = r_cnt - c_one;
                    w_en_n = 1'b0;
                    w_busy = 1'b1;
                end
            end

            ST_FINISH: begin
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_code   <= 2'b00;
            r_cnt    <= '0;
            r_dwell  <= c_one;
            r_mode   <= 1'b0;
            r_en_n   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_code   <= w_code;
            r_cnt    <= w_cnt;
            r_dwell  <= w_dwell;
            r_mode   <= w_mode;
            r_en_n   <= w_en_n;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_strobe <= w_strobe;
        end
    end

    assign bus.en_n        = r_en_n;
    assign bus.w1          = r_code[1];
    assign bus.w0          = r_code[0];
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.code_strobe = r_strobe;

endmodule
`default_nettype wire
